// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline control logic.
//   state_e     : stall controller FSM states (RUN, MEM_WAIT)
//   REG_ADDR_W  : register-file address width
//   STALL_CNT_W : width of the stall-cycle counter
package cpu_ctrl_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned STALL_CNT_W = 32;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector.
// A hazard exists when the instruction in EX is a load whose destination (not x0)
// is read by the instruction in ID.
// Ports:
//   mem_read_i : EX instruction is a load
//   ex_rd_i    : EX destination register
//   id_rs1_i   : ID source register 1
//   id_rs2_i   : ID source register 2
//   hazard_o   : load-use hazard present
module hazard_detect
    import cpu_ctrl_pkg::*;
(
    input  logic                  mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    output logic                  hazard_o
);

    always_comb begin
        hazard_o = mem_read_i && (ex_rd_i != '0) &&
                   ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    end

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall controller: inserts load-use bubbles, freezes the back end on
// data-cache misses and delivers IF/ID flushes (deferring them across stalls).
// Optional feature: define STALL_CNT_EN to build a saturating stall-cycle counter;
// otherwise stall_cnt_o is tied to zero.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   IDEX_MemRead_i, IDEX_Rd_i : load flag / destination of the EX instruction
//   IFID_Rs1_i, IFID_Rs2_i  : sources of the ID instruction
//   dcache_req_i/ack_i      : MEM-stage access valid / cache completed access
//   flush_i                 : taken-branch flush pulse
//   PCWrite_o, IFID_Write_o : PC and IF/ID enables
//   IFID_Flush_o            : clear IF/ID to a NOP
//   MUX_Control_select_o    : zero ID control signals (bubble)
//   pipe_stall_o            : freeze ID/EX, EX/MEM, MEM/WB
//   stall_cnt_o             : stall-cycle count
module stall_controller
    import cpu_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0]  IDEX_Rd_i,
    input  logic [REG_ADDR_W-1:0]  IFID_Rs1_i,
    input  logic [REG_ADDR_W-1:0]  IFID_Rs2_i,
    input  logic                   dcache_req_i,
    input  logic                   dcache_ack_i,
    input  logic                   flush_i,
    output logic                   PCWrite_o,
    output logic                   IFID_Write_o,
    output logic                   IFID_Flush_o,
    output logic                   MUX_Control_select_o,
    output logic                   pipe_stall_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    state_e state_q, state_d;
    logic   flush_pend_q, flush_pend_d;
    logic   hazard;
    logic   miss;

    hazard_detect u_hazard_detect (
        .mem_read_i (IDEX_MemRead_i),
        .ex_rd_i    (IDEX_Rd_i),
        .id_rs1_i   (IFID_Rs1_i),
        .id_rs2_i   (IFID_Rs2_i),
        .hazard_o   (hazard)
    );

    assign miss = dcache_req_i && !dcache_ack_i;

    always_comb begin
        state_d              = state_q;
        flush_pend_d         = flush_pend_q;
        PCWrite_o            = 1'b1;
        IFID_Write_o         = 1'b1;
        IFID_Flush_o         = 1'b0;
        MUX_Control_select_o = 1'b0;
        pipe_stall_o         = 1'b0;

        unique case (state_q)
            RUN: begin
                if (miss) begin
                    // Miss wins over load-use; any flush waits for the release.
                    pipe_stall_o = 1'b1;
                    PCWrite_o    = 1'b0;
                    IFID_Write_o = 1'b0;
                    flush_pend_d = flush_pend_q | flush_i;
                    state_d      = MEM_WAIT;
                end else begin
                    IFID_Flush_o = flush_i | flush_pend_q;
                    flush_pend_d = 1'b0;
                    if (hazard) begin
                        MUX_Control_select_o = 1'b1;
                        IFID_Write_o         = 1'b0;
                        // A flush redirects fetch, so the PC must still advance.
                        PCWrite_o            = IFID_Flush_o;
                    end
                end
            end
            MEM_WAIT: begin
                // Ack cycle is released but still counts as MEM_WAIT: no hazard
                // check and no flush delivery until the following RUN cycle.
                flush_pend_d = flush_pend_q | flush_i;
                if (dcache_ack_i) begin
                    state_d = RUN;
                end else begin
                    pipe_stall_o = 1'b1;
                    PCWrite_o    = 1'b0;
                    IFID_Write_o = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((pipe_stall_o || MUX_Control_select_o) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
